// File: rtl/tt_load_buffer_drain_pkg.sv
// Shared types and constants for the load-buffer drain responder.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package tt_vpu_lq_pkg;

    localparam int LQID_W    = 3;
    localparam int LQ_DEPTH  = 1 << LQID_W;
    localparam int LQ_DATA_W = 64;

    typedef logic [LQID_W-1:0] lqid_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_t;

    typedef struct packed {
        logic                 valid;
        logic [LQ_DATA_W-1:0] data;
    } lq_entry_t;

    // The lqid space is exactly LQ_DEPTH wide, so the natural 3-bit overflow is the ring wrap.
    function automatic lqid_t lqid_next(input lqid_t id);
        return lqid_t'(id + 1'b1);
    endfunction

endpackage

// File: rtl/tt_load_buffer_drain_if.sv
// Scoreboard/load-return/writeback signal bundle for the drain responder.
// Latency: n/a (wires only).
// Backpressure: writeback beats stall while i_wb_ready is low.
interface tt_load_buffer_drain_if #(
    parameter int DATA_W = tt_vpu_lq_pkg::LQ_DATA_W
);
    localparam int LQID_W = tt_vpu_lq_pkg::LQID_W;

    // load return fill port
    logic              i_lq_wr_valid;
    logic [LQID_W-1:0] i_lq_wr_lqid;
    logic [DATA_W-1:0] i_lq_wr_data;

    // scoreboard control
    logic              i_flush;
    logic              i_drain_load_buffer;
    logic [LQID_W-1:0] i_drain_ref_count;
    logic [LQID_W-1:0] i_drain_lqid_start;
    logic              o_draining_load_buffer;

    // writeback path
    logic              o_wb_valid;
    logic [DATA_W-1:0] o_wb_data;
    logic [LQID_W-1:0] o_wb_lqid;
    logic              i_wb_ready;

    // commit return to scoreboard
    logic              o_lq_commit;
    logic [LQID_W-1:0] o_dest_lqid;
    logic              o_err_overwrite;

    // Scoreboard / load-return / writeback-sink side.
    modport master (
        output i_lq_wr_valid, i_lq_wr_lqid, i_lq_wr_data,
        output i_flush, i_drain_load_buffer, i_drain_ref_count, i_drain_lqid_start,
        output i_wb_ready,
        input  o_draining_load_buffer, o_wb_valid, o_wb_data, o_wb_lqid,
        input  o_lq_commit, o_dest_lqid, o_err_overwrite
    );

    // Drain responder side.
    modport slave (
        input  i_lq_wr_valid, i_lq_wr_lqid, i_lq_wr_data,
        input  i_flush, i_drain_load_buffer, i_drain_ref_count, i_drain_lqid_start,
        input  i_wb_ready,
        output o_draining_load_buffer, o_wb_valid, o_wb_data, o_wb_lqid,
        output o_lq_commit, o_dest_lqid, o_err_overwrite
    );

endinterface

// File: rtl/tt_lq_storage.sv
// 8-entry load buffer: one write port, one read port at the drain pointer, valid tracking.
// Latency: writes visible the cycle after the edge (no bypass); read is combinational.
// Backpressure: none; every write is accepted, overwriting a valid entry flags an error.
module tt_lq_storage
    import tt_vpu_lq_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 wr_valid,
    input  lqid_t                wr_lqid,
    input  logic [LQ_DATA_W-1:0] wr_data,
    input  logic                 clr_valid,
    input  lqid_t                rd_lqid,
    output lq_entry_t            rd_entry,
    output logic                 err_overwrite
);

    lq_entry_t mem_q [LQ_DEPTH];

    // Entry update: flush beats everything; a write to the entry being drained wins over its clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                mem_q[i].valid <= 1'b0;
            end
        end else begin
            if (clr_valid) begin
                mem_q[rd_lqid].valid <= 1'b0;
            end
            if (wr_valid) begin
                mem_q[wr_lqid].valid <= 1'b1;
                mem_q[wr_lqid].data  <= wr_data;
            end
        end
    end

    // Sticky overwrite error: a fill landing on an entry that has not been drained yet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_overwrite <= 1'b0;
        end else if (!flush && wr_valid && mem_q[wr_lqid].valid) begin
            err_overwrite <= 1'b1;
        end
    end

    assign rd_entry = mem_q[rd_lqid];

endmodule

// File: rtl/tt_load_buffer_drain.sv
// Drain responder: walks ref_count lqids from lqid_start and writes each buffered entry back.
// Latency: first beat the cycle after acceptance if the entry is valid; 1 entry/cycle after.
// Backpressure: beat holds (data stable) while i_wb_ready is low; stalls while entry invalid.
module tt_load_buffer_drain
    import tt_vpu_lq_pkg::*;
#(
    parameter int DATA_W = LQ_DATA_W
)(
    input  logic                  clk,
    input  logic                  reset,
    tt_load_buffer_drain_if.slave bus
);

    drain_state_t state_q, state_d;
    lqid_t        ptr_q, ptr_d;
    lqid_t        remaining_q, remaining_d;

    lq_entry_t    rd_entry;
    logic         wb_valid;
    logic         commit;
    logic         err_overwrite;

    tt_lq_storage u_storage (
        .clk           (clk),
        .reset         (reset),
        .flush         (bus.i_flush),
        .wr_valid      (bus.i_lq_wr_valid),
        .wr_lqid       (bus.i_lq_wr_lqid),
        .wr_data       (bus.i_lq_wr_data),
        .clr_valid     (commit),
        .rd_lqid       (ptr_q),
        .rd_entry      (rd_entry),
        .err_overwrite (err_overwrite)
    );

    // A beat exists only in DRAIN with the pointed entry present; a flush suppresses it.
    assign wb_valid = (state_q == DRAIN) && rd_entry.valid && !bus.i_flush;
    assign commit   = wb_valid && bus.i_wb_ready;

    // State and walk counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
        end
    end

    // Next state: accept only in IDLE; DONE lasts one cycle so a still-held serviced request is ignored.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        if (bus.i_flush) begin
            ptr_d       = '0;
            remaining_d = '0;
            state_d     = (state_q == DRAIN) ? DONE : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_drain_load_buffer) begin
                        ptr_d       = bus.i_drain_lqid_start;
                        remaining_d = bus.i_drain_ref_count;
                        state_d     = (bus.i_drain_ref_count != '0) ? DRAIN : DONE;
                    end
                end
                DRAIN: begin
                    if (commit) begin
                        ptr_d       = lqid_next(ptr_q);
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == lqid_t'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.o_draining_load_buffer = (state_q == DRAIN);
    assign bus.o_wb_valid             = wb_valid;
    // Data is masked when no beat is offered so the bus stays quiet outside real writebacks.
    assign bus.o_wb_data              = wb_valid ? DATA_W'(rd_entry.data) : '0;
    assign bus.o_wb_lqid              = ptr_q;
    assign bus.o_lq_commit            = commit;
    assign bus.o_dest_lqid            = ptr_q;
    assign bus.o_err_overwrite        = err_overwrite;

endmodule

// File: tb/tb_tt_load_buffer_drain.sv
// Directed bench for the load-buffer drain responder.
// Latency: inputs driven at negedge, outputs sampled 1ns later (well away from posedge).
// Backpressure: exercised by toggling i_wb_ready.
module tb_tt_load_buffer_drain;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    tt_load_buffer_drain_if #(.DATA_W(64)) bus ();

    tt_load_buffer_drain #(.DATA_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle of stimulus: set inputs after negedge, let combinational outputs settle.
    task automatic drive(input bit drn, input logic [2:0] st, input logic [2:0] cnt,
                         input bit rdy, input bit wv, input logic [2:0] wid,
                         input logic [63:0] wd, input bit fl);
        @(negedge clk);
        bus.i_drain_load_buffer = drn;
        bus.i_drain_lqid_start  = st;
        bus.i_drain_ref_count   = cnt;
        bus.i_wb_ready          = rdy;
        bus.i_lq_wr_valid       = wv;
        bus.i_lq_wr_lqid        = wid;
        bus.i_lq_wr_data        = wd;
        bus.i_flush             = fl;
        #1;
    endtask

    task automatic wr(input logic [2:0] id, input logic [63:0] d);
        drive(1'b0, 3'd0, 3'd0, 1'b1, 1'b1, id, d, 1'b0);
    endtask

    task automatic cyc(input bit drn, input bit rdy);
        drive(drn, 3'd0, 3'd0, rdy, 1'b0, 3'd0, 64'd0, 1'b0);
    endtask

    task automatic req(input logic [2:0] st, input logic [2:0] cnt);
        drive(1'b1, st, cnt, 1'b1, 1'b0, 3'd0, 64'd0, 1'b0);
    endtask

    task automatic expect_beat(input string tag, input logic [2:0] id, input logic [63:0] d);
        check_eq({tag, ".draining"}, 64'(bus.o_draining_load_buffer), 64'd1);
        check_eq({tag, ".commit"},   64'(bus.o_lq_commit), 64'd1);
        check_eq({tag, ".dest"},     64'(bus.o_dest_lqid), 64'(id));
        check_eq({tag, ".wb_lqid"},  64'(bus.o_wb_lqid), 64'(id));
        check_eq({tag, ".wb_data"},  bus.o_wb_data, d);
    endtask

    task automatic expect_quiet(input string tag, input bit draining);
        check_eq({tag, ".draining"}, 64'(bus.o_draining_load_buffer), 64'(draining));
        check_eq({tag, ".wb_valid"}, 64'(bus.o_wb_valid), 64'd0);
        check_eq({tag, ".commit"},   64'(bus.o_lq_commit), 64'd0);
    endtask

    task automatic expect_all_zero(input string tag);
        expect_quiet(tag, 1'b0);
        check_eq({tag, ".dest"},    64'(bus.o_dest_lqid), 64'd0);
        check_eq({tag, ".wb_lqid"}, 64'(bus.o_wb_lqid), 64'd0);
        check_eq({tag, ".wb_data"}, bus.o_wb_data, 64'd0);
        check_eq({tag, ".err"},     64'(bus.o_err_overwrite), 64'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        bus.i_drain_load_buffer = 1'b0;
        bus.i_drain_lqid_start  = '0;
        bus.i_drain_ref_count   = '0;
        bus.i_wb_ready          = 1'b0;
        bus.i_lq_wr_valid       = 1'b0;
        bus.i_lq_wr_lqid        = '0;
        bus.i_lq_wr_data        = '0;
        bus.i_flush             = 1'b0;

        // Reset state
        #2;
        expect_all_zero("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        expect_all_zero("rst_rel");

        // Basic drain 2,3,4
        wr(3'd2, 64'hA2A2_0000_0000_0002);
        wr(3'd3, 64'hA3A3_0000_0000_0003);
        wr(3'd4, 64'hA4A4_0000_0000_0004);
        req(3'd2, 3'd3);
        expect_quiet("basic.acc", 1'b0);
        cyc(1'b1, 1'b1);
        expect_beat("basic.b0", 3'd2, 64'hA2A2_0000_0000_0002);
        cyc(1'b1, 1'b1);
        expect_beat("basic.b1", 3'd3, 64'hA3A3_0000_0000_0003);
        cyc(1'b1, 1'b1);
        expect_beat("basic.b2", 3'd4, 64'hA4A4_0000_0000_0004);
        cyc(1'b1, 1'b1);
        expect_quiet("basic.done", 1'b0);
        cyc(1'b0, 1'b1);
        expect_quiet("basic.idle", 1'b0);

        // Drained entries are gone: a 1-entry drain of lqid 2 stalls until flushed
        req(3'd2, 3'd1);
        cyc(1'b0, 1'b1);
        expect_quiet("clr.s0", 1'b1);
        cyc(1'b0, 1'b1);
        expect_quiet("clr.s1", 1'b1);
        drive(1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 64'd0, 1'b1);
        expect_quiet("flush.cyc", 1'b1);
        cyc(1'b0, 1'b1);
        expect_quiet("flush.done", 1'b0);
        check_eq("flush.ptr", 64'(bus.o_dest_lqid), 64'd0);
        cyc(1'b0, 1'b1);

        // Wrap 6,7,0
        wr(3'd6, 64'hB6);
        wr(3'd7, 64'hB7);
        wr(3'd0, 64'hB0);
        req(3'd6, 3'd3);
        cyc(1'b0, 1'b1);
        expect_beat("wrap.b0", 3'd6, 64'hB6);
        cyc(1'b0, 1'b1);
        expect_beat("wrap.b1", 3'd7, 64'hB7);
        cyc(1'b0, 1'b1);
        expect_beat("wrap.b2", 3'd0, 64'hB0);
        cyc(1'b0, 1'b1);
        expect_quiet("wrap.done", 1'b0);
        check_eq("wrap.ptr_end", 64'(bus.o_dest_lqid), 64'd1);

        // Data late: entry 2 present, entry 1 arrives 4 cycles after accept
        wr(3'd2, 64'hC2);
        req(3'd1, 3'd2);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1);
            expect_quiet($sformatf("late.s%0d", i), 1'b1);
        end
        wr(3'd1, 64'hC1);
        expect_quiet("late.nobypass", 1'b1);
        cyc(1'b0, 1'b1);
        expect_beat("late.b0", 3'd1, 64'hC1);
        cyc(1'b0, 1'b1);
        expect_beat("late.b1", 3'd2, 64'hC2);
        cyc(1'b0, 1'b1);
        expect_quiet("late.done", 1'b0);

        // Backpressure: ready 0,1,0,1
        wr(3'd3, 64'hD3);
        wr(3'd4, 64'hD4);
        req(3'd3, 3'd2);
        cyc(1'b0, 1'b0);
        check_eq("bp.s0.valid", 64'(bus.o_wb_valid), 64'd1);
        check_eq("bp.s0.commit", 64'(bus.o_lq_commit), 64'd0);
        check_eq("bp.s0.data", bus.o_wb_data, 64'hD3);
        cyc(1'b0, 1'b1);
        expect_beat("bp.b0", 3'd3, 64'hD3);
        cyc(1'b0, 1'b0);
        check_eq("bp.s1.valid", 64'(bus.o_wb_valid), 64'd1);
        check_eq("bp.s1.commit", 64'(bus.o_lq_commit), 64'd0);
        check_eq("bp.s1.data", bus.o_wb_data, 64'hD4);
        cyc(1'b0, 1'b1);
        expect_beat("bp.b1", 3'd4, 64'hD4);
        cyc(1'b0, 1'b1);
        expect_quiet("bp.done", 1'b0);

        // count=0 with request held: IDLE->DONE->IDLE, re-accept on 3rd cycle
        wr(3'd6, 64'hE6);
        req(3'd5, 3'd0);
        req(3'd7, 3'd3);
        expect_quiet("zero.done", 1'b0);
        check_eq("zero.ptr", 64'(bus.o_dest_lqid), 64'd5);
        req(3'd6, 3'd1);
        expect_quiet("zero.reacc", 1'b0);
        cyc(1'b0, 1'b1);
        expect_beat("zero.b0", 3'd6, 64'hE6);
        cyc(1'b0, 1'b1);
        expect_quiet("zero.done2", 1'b0);

        // Reset mid-drain after one commit
        wr(3'd0, 64'hF0);
        wr(3'd1, 64'hF1);
        wr(3'd2, 64'hF2);
        req(3'd0, 3'd3);
        cyc(1'b1, 1'b1);
        expect_beat("mid.b0", 3'd0, 64'hF0);
        cyc(1'b1, 1'b1);
        reset = 1'b1;
        #1;
        expect_all_zero("mid.rst");
        cyc(1'b1, 1'b1);
        expect_all_zero("mid.rst_hold");
        reset = 1'b0;
        wr(3'd0, 64'hF0);
        wr(3'd1, 64'hF1);
        wr(3'd2, 64'hF2);
        req(3'd0, 3'd3);
        cyc(1'b0, 1'b1);
        expect_beat("re.b0", 3'd0, 64'hF0);
        cyc(1'b0, 1'b1);
        expect_beat("re.b1", 3'd1, 64'hF1);
        cyc(1'b0, 1'b1);
        expect_beat("re.b2", 3'd2, 64'hF2);
        cyc(1'b0, 1'b1);
        expect_quiet("re.done", 1'b0);

        // Overwrite error, sticky, and write-wins-over-commit
        wr(3'd5, 64'h51);
        check_eq("ovw.first", 64'(bus.o_err_overwrite), 64'd0);
        wr(3'd5, 64'h52);
        check_eq("ovw.same_cyc", 64'(bus.o_err_overwrite), 64'd0);
        cyc(1'b0, 1'b1);
        check_eq("ovw.set", 64'(bus.o_err_overwrite), 64'd1);
        req(3'd5, 3'd1);
        drive(1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 3'd5, 64'h53, 1'b0);
        expect_beat("ovw.commit", 3'd5, 64'h52);
        cyc(1'b0, 1'b1);
        expect_quiet("ovw.done", 1'b0);
        cyc(1'b0, 1'b1);
        req(3'd5, 3'd1);
        cyc(1'b0, 1'b1);
        expect_beat("ovw.kept", 3'd5, 64'h53);
        cyc(1'b0, 1'b1);
        drive(1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 64'd0, 1'b1);
        cyc(1'b0, 1'b1);
        check_eq("ovw.after_flush", 64'(bus.o_err_overwrite), 64'd1);
        cyc(1'b0, 1'b1);
        check_eq("ovw.sticky", 64'(bus.o_err_overwrite), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tt_load_buffer_drain.md
Name: tt_load_buffer_drain

Overview:
- Responder side of the scoreboard's load-buffer drain handshake.
- Holds returned load data in an 8-entry load buffer indexed by lqid.
- When the scoreboard requests a drain, it walks ref_count consecutive lqids from lqid_start (mod 8) and writes each entry back to the VRF path.
- Each writeback pulses lq_commit/dest_lqid back to the scoreboard, so ref_count reaches 0 and the instruction completes.

Parameters:
- DATA_W, 64, width of one load-buffer entry / writeback beat
- LQ_DEPTH, 8, entries; fixed to 2^3 to match the 3-bit lqid

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- i_lq_wr_valid  input  1  load return data valid
- i_lq_wr_lqid  input  3  entry written by the load return
- i_lq_wr_data  input  DATA_W  load return data
- i_flush  input  1  synchronous abort: clear buffer, return to IDLE
- i_drain_load_buffer  input  1  drain request (level) from scoreboard
- i_drain_ref_count  input  3  number of entries to drain
- i_drain_lqid_start  input  3  first lqid to drain
- o_draining_load_buffer  output  1  drain in progress
- o_wb_valid  output  1  writeback beat valid
- o_wb_data  output  DATA_W  writeback data
- o_wb_lqid  output  3  lqid of the beat
- i_wb_ready  input  1  writeback sink ready
- o_lq_commit  output  1  entry committed this cycle
- o_dest_lqid  output  3  lqid committed
- o_err_overwrite  output  1  sticky: write hit an already-valid entry

Behaviour:
- Reset (async, active-high) clears:
  - state to IDLE
  - all entry valids, ptr, remaining, o_err_overwrite
- Every output is 0 during and after reset until the first event.
- Buffer fill:
  - i_lq_wr_valid sets valid[lqid] and stores data at the clock edge.
  - Writing an already-valid entry still overwrites, and sets o_err_overwrite (sticky until reset).
- FSM states: IDLE, DRAIN, DONE.
  - IDLE: if i_drain_load_buffer, latch ptr=i_drain_lqid_start and remaining=i_drain_ref_count.
    - remaining!=0 -> DRAIN.
    - remaining==0 -> DONE; no beats are issued.
  - DRAIN:
    - o_wb_valid = valid[ptr], o_wb_data = data[ptr], o_wb_lqid = ptr.
    - On o_wb_valid && i_wb_ready: clear valid[ptr], ptr=ptr+1 (3-bit wrap 7->0), remaining-1.
    - When remaining reaches 0 -> DONE.
    - If valid[ptr]==0, stall; o_wb_valid stays low.
  - DONE: exactly 1 cycle, then IDLE. A request seen in DONE is ignored, because the scoreboard drops a serviced request only one cycle after draining falls.
- o_draining_load_buffer = (state==DRAIN), registered state decode.
- o_lq_commit = o_wb_valid && i_wb_ready, same cycle as the beat. o_dest_lqid = ptr.
- Latency: first beat is possible in the cycle after acceptance, given data is valid.
  - Throughput is 1 entry/cycle.
  - N entries: draining is high for N cycles minimum.
- Simultaneous write to ptr while in DRAIN with valid[ptr]==0:
  - The write lands at the edge; the beat is issued next cycle.
  - No same-cycle bypass.
- Simultaneous write to an entry being committed this cycle: the write wins, valid stays 1, and o_err_overwrite sets.
- i_flush:
  - Highest priority except reset.
  - Clears valids, ptr and remaining; state -> DONE if it was DRAIN, else IDLE.
  - No commit pulse in the flush cycle.
  - o_err_overwrite is not cleared.
- Reset mid-drain: immediate return to IDLE; no further commits.
- A new drain is accepted only in IDLE; the ref_count/lqid inputs are sampled only at acceptance.

Decomposition:
- Shared package tt_vpu_lq_pkg:
  - LQ_DEPTH and LQID_W=3
  - drain state enum {IDLE, DRAIN, DONE}
  - lq_entry_t struct {valid, data}
- One natural sub-module, tt_lq_storage: 8-entry register array with write port, read mux at ptr, and valid clear/set/overwrite detect.
- The FSM and counters stay in the top.

Test Plan:
- Fill lqid 2,3,4; drain start=2, ref_count=3, wb_ready=1 -> commits lqid 2,3,4 on 3 consecutive cycles; draining high 3 cycles; DONE 1 cycle; valids cleared.
- Wrap: fill 6,7,0; drain start=6, count=3 -> o_dest_lqid sequence 6,7,0; ptr ends at 1.
- Data late: drain start=1, count=2, entry 1 written 4 cycles after accept -> no beat for 4 cycles, then commits 1 and 2; draining held throughout.
- Backpressure: wb_ready toggles 0,1,0,1 with 2 valid entries -> commits only on ready cycles; data stable while stalled.
- count=0 and request held high -> IDLE->DONE->IDLE, zero commits; re-accepts on the 3rd cycle if still requested.
- Reset asserted mid-drain after 1 of 3 commits -> all outputs 0 asynchronously; after release, same request restarts cleanly. Overwrite of a valid entry -> o_err_overwrite=1 and sticky.
